huffman_packer: RTL
===================

Name: huffman_packer

Overview:
- Downstream stage of the Huffman encoder. On the encoder's code_valid pulse it captures the six code/mask pairs (HC1..HC6, M1..M6).
- It then accepts the gray symbol stream (values 1..6) and replaces each symbol with its variable-length code.
- It packs the code bits MSB-first into 8-bit output words under a valid/ready handshake.
- An end-of-stream request flushes the last partial byte with zero padding.

Parameters:
BITCNT_W, 16, width of total coded-bit counter output (saturating)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
code_valid  input  1  one-cycle pulse from encoder; HC/M inputs valid this cycle
HC1..HC6  input  8 each  Huffman code for symbol i, right-aligned
M1..M6  input  8 each  mask for symbol i, contiguous low-aligned ones (e.g. 8'h07 = 3-bit code)
sym_valid  input  1  symbol present on sym_data
sym_data  input  8  gray symbol, legal values 1..6
sym_ready  output  1  packer accepts symbol this cycle
eos  input  1  end-of-stream request (single-cycle pulse)
out_valid  output  1  out_data holds a packed byte
out_data  output  8  packed byte, bit 7 = oldest code bit
out_last  output  1  qualifies final byte of stream
out_ready  input  1  downstream accepts byte this cycle
sym_err  output  1  one-cycle pulse: accepted symbol illegal or has zero mask
done  output  1  one-cycle pulse: flush complete
bit_count  output  BITCNT_W  total code bits appended since table load, saturates at all-ones

Behaviour:
- Reset values: sym_ready=0, out_valid=0, out_data=0, out_last=0, sym_err=0, done=0, bit_count=0, table cleared, state=IDLE.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: code_valid=1 captures HCi and Mi. Per symbol, len_i = popcount(Mi) (0..8) and code_i = HCi & Mi. Clears the accumulator and bit_count, then goes to RUN next cycle. code_valid in any other state is ignored.
- Accumulator: acc[14:0] left-aligned pending bits, acc[14] oldest; fill count cnt 0..15.
- sym_ready = (state==RUN) && (cnt<8). It is driven from registers only, with no combinational path from out_ready.
- Symbol accept (sym_valid && sym_ready):
  - A legal symbol with len>0 appends the low len bits of its code, MSB first, at position cnt. cnt += len, and bit_count += len, saturating.
  - sym_data outside 1..6, or len==0, appends nothing and pulses sym_err the next cycle.
- out_valid = (cnt>=8), or (state==FLUSH && cnt>0).
- out_data = acc[14:7], with unused low bits forced to 0 when cnt<8.
- On a byte fire (out_valid && out_ready): acc <<= 8, cnt -= min(cnt,8).
- Simultaneous byte fire and symbol accept in one cycle: the shift applies first, then the new code is appended at the post-shift position. cnt_next = cnt - 8 + len.
- out_data/out_valid remain stable while out_ready=0.
- RUN: eos=1 moves to FLUSH next cycle. A symbol accepted in the same cycle as eos is still appended. eos in IDLE, FLUSH or DONE is ignored.
- FLUSH: sym_ready=0. Full bytes are emitted normally. out_last=1 on the byte whose fire brings cnt to 0, including a zero-padded partial byte. After that fire, go to DONE.
- FLUSH entered with cnt==0: no byte is emitted and out_last never asserts; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. The table is retained, but RUN requires a new code_valid.
- Reset asserted mid-operation: all state and outputs return to reset values asynchronously, and pending bits are discarded.

Test Plan:
- Load table HC/M = 1:0/01, 2:10/03, 3:110/07, 4:1110/0F, 5:11110/1F, 6:11111/1F. Send symbols 1,2,3,4, then eos, with out_ready=1.
  -> bytes 0x5B, then 0x80 with out_last=1; bit_count=10; done pulse.
- Same table, send symbol 6 eight times, then eos.
  -> five bytes of 0xFF, out_last only on the 5th, no padding byte; bit_count=40.
- out_ready=0, send 6,6 (cnt=10).
  -> out_valid=1 with out_data=0xFF held stable; sym_ready=0.
  -> Raise out_ready: one 0xFF fires, cnt=2, sym_ready returns to 1.
- Send sym_data=0, 7, then 3, then eos.
  -> sym_err pulses twice; only code 110 is packed; final byte 0xC0 with out_last=1; bit_count=3.
- eos immediately after table load.
  -> no out_valid; done pulses 2 cycles after eos.
  -> A second eos or code_valid during FLUSH/DONE has no effect.
- Assert reset asynchronously mid-stream with cnt=5.
  -> All outputs 0 immediately.
  -> After release, the symbol stream is refused (sym_ready=0) until code_valid reloads the table.

Source files
------------

// File: rtl/huffman_packer.sv
// ============================================================================
//  huffman_packer
//  Replaces gray symbols with their Huffman codes and packs the bits
//  MSB-first into bytes under a valid/ready handshake.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module huffman_packer #(
    parameter int BITCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                code_valid,
    input  logic [7:0]          HC1,
    input  logic [7:0]          HC2,
    input  logic [7:0]          HC3,
    input  logic [7:0]          HC4,
    input  logic [7:0]          HC5,
    input  logic [7:0]          HC6,
    input  logic [7:0]          M1,
    input  logic [7:0]          M2,
    input  logic [7:0]          M3,
    input  logic [7:0]          M4,
    input  logic [7:0]          M5,
    input  logic [7:0]          M6,
    input  logic                sym_valid,
    input  logic [7:0]          sym_data,
    output logic                sym_ready,
    input  logic                eos,
    output logic                out_valid,
    output logic [7:0]          out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic                sym_err,
    output logic                done,
    output logic [BITCNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]  code_tbl [6];
    logic [3:0]  len_tbl  [6];
    logic [7:0]  hc_in    [6];
    logic [7:0]  m_in     [6];

    logic [14:0] acc;
    logic [3:0]  cnt;

    logic [14:0] acc_next;
    logic [3:0]  cnt_next;
    logic [14:0] acc_base;
    logic [3:0]  cnt_base;
    logic [14:0] aligned;
    logic [BITCNT_W-1:0] bc_next;
    logic [BITCNT_W:0]   bc_sum;

    logic        sym_legal;
    logic [7:0]  sel_code;
    logic [3:0]  sel_len;
    logic        fire;
    logic        accept;
    logic        good_sym;
    logic        load;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        hc_in[0] = HC1;  hc_in[1] = HC2;  hc_in[2] = HC3;
        hc_in[3] = HC4;  hc_in[4] = HC5;  hc_in[5] = HC6;
        m_in[0]  = M1;   m_in[1]  = M2;   m_in[2]  = M3;
        m_in[3]  = M4;   m_in[4]  = M5;   m_in[5]  = M6;
    end

    // Symbol lookup; anything outside 1..6 is flagged illegal.
    always_comb begin
        sym_legal = 1'b1;
        sel_code  = 8'h00;
        sel_len   = 4'd0;
        case (sym_data)
            8'd1: begin sel_code = code_tbl[0]; sel_len = len_tbl[0]; end
            8'd2: begin sel_code = code_tbl[1]; sel_len = len_tbl[1]; end
            8'd3: begin sel_code = code_tbl[2]; sel_len = len_tbl[2]; end
            8'd4: begin sel_code = code_tbl[3]; sel_len = len_tbl[3]; end
            8'd5: begin sel_code = code_tbl[4]; sel_len = len_tbl[4]; end
            8'd6: begin sel_code = code_tbl[5]; sel_len = len_tbl[5]; end
            default: sym_legal = 1'b0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state and handshake outputs, all derived from registers
    always_comb begin
        state_next = state;
        sym_ready  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        done       = 1'b0;

        sym_ready = (state == ST_RUN) && (cnt < 4'd8);
        out_valid = (cnt >= 4'd8) || ((state == ST_FLUSH) && (cnt != 4'd0));
        out_last  = (state == ST_FLUSH) && (cnt != 4'd0) && (cnt <= 4'd8);
        done      = (state == ST_DONE);

        case (state)
            ST_IDLE:  if (code_valid) state_next = ST_RUN;
            ST_RUN:   if (eos) state_next = ST_FLUSH;
            ST_FLUSH: begin
                if (cnt == 4'd0) begin
                    state_next = ST_DONE;
                end else if (out_valid && out_ready && (cnt <= 4'd8)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: shift out the fired byte first, then append at the new fill point.
    always_comb begin
        fire     = out_valid && out_ready;
        accept   = sym_valid && sym_ready;
        good_sym = accept && sym_legal && (sel_len != 4'd0);
        load     = (state == ST_IDLE) && code_valid;

        acc_base = fire ? {acc[6:0], 8'h00} : acc;
        cnt_base = cnt;
        if (fire) begin
            cnt_base = (cnt >= 4'd8) ? (cnt - 4'd8) : 4'd0;
        end

        aligned  = ({7'b0, sel_code} << (4'd15 - sel_len)) >> cnt_base;
        acc_next = good_sym ? (acc_base | aligned) : acc_base;
        cnt_next = good_sym ? (cnt_base + sel_len) : cnt_base;

        bc_sum   = {1'b0, bit_count} + (BITCNT_W+1)'(sel_len);
        bc_next  = bit_count;
        if (good_sym) begin
            bc_next = bc_sum[BITCNT_W] ? {BITCNT_W{1'b1}} : bc_sum[BITCNT_W-1:0];
        end

        out_data = acc[14:7];
        if (cnt < 4'd8) begin
            out_data = acc[14:7] & ~(8'hFF >> cnt[2:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            bit_count <= '0;
            sym_err   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                code_tbl[i] <= 8'h00;
                len_tbl[i]  <= 4'd0;
            end
        end else if (load) begin
            acc       <= '0;
            cnt       <= '0;
            bit_count <= '0;
            sym_err   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                code_tbl[i] <= hc_in[i] & m_in[i];
                len_tbl[i]  <= popcount8(m_in[i]);
            end
        end else begin
            acc       <= acc_next;
            cnt       <= cnt_next;
            bit_count <= bc_next;
            sym_err   <= accept && !good_sym;
        end
    end

endmodule

`default_nettype wire
